data_mem_responder: RTL and testbench

Responder side of the core controller's data-memory interface. It accepts one read and/or write request at a time on the memrd/memwr strobes and services it after a fixed, programmable latency. It returns read data with a single-cycle valid pulse and holds a busy flag so the multi-cycle controller can stall its state sequencing. It sits between the controller and the on-chip data RAM.

---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_mem_responder_mem_array.sv | 32 +++
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    localparam int DATA_W    = 32;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_LAT   = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-clock word RAM: one registered read port, one write port.
// A read and a write to the same address on one edge return the old word.
module mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the controller's data-memory port.
// Optional out-of-range detection is enabled by defining MEM_RANGE_CHECK_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LAT   = DEF_LAT,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     memaddrOut,
    input  logic              memrd,
    input  logic [AW-1:0]     memaddrIn,
    input  logic [DATA_W-1:0] memdataIn,
    input  logic              memwr,
    output logic [DATA_W-1:0] memdata,
    output logic              memvalid,
    output logic              membusy,
    output logic              memerr
);

    localparam int IW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    // In IDLE with LAT=1 the RAM access happens on the accepting edge, so the
    // live inputs are used there; otherwise the captured request is used.
    logic              idle;
    logic              req_rd, req_wr;
    logic [AW-1:0]     req_raddr, req_waddr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_oob, wr_oob;
    logic              fire;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign idle      = (state_q == S_IDLE);
    assign req_rd    = idle ? memrd      : rd_q;
    assign req_wr    = idle ? memwr      : wr_q;
    assign req_raddr = idle ? memaddrOut : raddr_q;
    assign req_waddr = idle ? memaddrIn  : waddr_q;
    assign req_wdata = idle ? memdataIn  : wdata_q;

`ifdef MEM_RANGE_CHECK_EN
    generate
        if (AW > IW) begin : g_range
            assign rd_oob = |req_raddr[AW-1:IW];
            assign wr_oob = |req_waddr[AW-1:IW];
        end else begin : g_no_range
            assign rd_oob = 1'b0;
            assign wr_oob = 1'b0;
        end
    endgenerate
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
    generate
        if (AW > IW) begin : g_wrap
            logic unused_hi;
            assign unused_hi = ^{req_raddr[AW-1:IW], req_waddr[AW-1:IW]};
        end
    endgenerate
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        zero_d  = zero_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (memrd || memwr) begin
                    rd_d    = memrd;
                    wr_d    = memwr;
                    raddr_d = memaddrOut;
                    waddr_d = memaddrIn;
                    wdata_d = memdataIn;
                    if (LAT == 1) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion status is latched on the edge that enters RESP.
        if (state_d == S_RESP) begin
            if (req_rd) begin
                zero_d = rd_oob;
            end
            err_d = (req_rd && rd_oob) || (req_wr && wr_oob);
        end
    end

    assign fire   = (state_d == S_RESP) && rst_n;
    assign ram_we = fire && req_wr && !wr_oob;
    assign ram_re = fire && req_rd;

    mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (req_waddr[IW-1:0]),
        .wdata (req_wdata),
        .re    (ram_re),
        .raddr (req_raddr[IW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // zero_q masks the RAM output register, which itself has no reset.
    assign memdata  = zero_q ? '0 : ram_rdata;
    assign memvalid = (state_q == S_RESP);
    assign membusy  = (state_q != S_IDLE);
    assign memerr   = memvalid && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LAT=2, LAT=1, LAT=15), DEPTH=64.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_s [3];
    logic        wr_s [3];
    logic [31:0] ao_s [3];
    logic [31:0] ai_s [3];
    logic [31:0] di_s [3];
    logic [31:0] d_o  [3];
    logic        v_o  [3];
    logic        b_o  [3];
    logic        e_o  [3];

    int checks = 0;
    int errors = 0;
    int lat_of [3] = '{2, 1, 15};

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .LAT(2), .AW(32)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .memaddrOut(ao_s[0]), .memrd(rd_s[0]), .memaddrIn(ai_s[0]),
        .memdataIn(di_s[0]), .memwr(wr_s[0]),
        .memdata(d_o[0]), .memvalid(v_o[0]), .membusy(b_o[0]), .memerr(e_o[0])
    );

    data_mem_responder #(.DEPTH(64), .LAT(1), .AW(32)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .memaddrOut(ao_s[1]), .memrd(rd_s[1]), .memaddrIn(ai_s[1]),
        .memdataIn(di_s[1]), .memwr(wr_s[1]),
        .memdata(d_o[1]), .memvalid(v_o[1]), .membusy(b_o[1]), .memerr(e_o[1])
    );

    data_mem_responder #(.DEPTH(64), .LAT(15), .AW(32)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .memaddrOut(ao_s[2]), .memrd(rd_s[2]), .memaddrIn(ai_s[2]),
        .memdataIn(di_s[2]), .memwr(wr_s[2]),
        .memdata(d_o[2]), .memvalid(v_o[2]), .membusy(b_o[2]), .memerr(e_o[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on responder w; checks exact latency, data, err, return to idle.
    task automatic req(input int w, input logic rd, input logic wr,
                       input logic [31:0] ao, input logic [31:0] ai, input logic [31:0] di,
                       input logic [31:0] exp_d, input logic exp_e);
        int   early;
        logic allbusy;
        early   = 0;
        allbusy = 1'b1;
        rd_s[w] = rd; wr_s[w] = wr; ao_s[w] = ao; ai_s[w] = ai; di_s[w] = di;
        tick();
        rd_s[w] = 1'b0; wr_s[w] = 1'b0;
        for (int k = 1; k < lat_of[w]; k++) begin
            if (v_o[w]) early++;
            allbusy = allbusy & b_o[w];
            tick();
        end
        chk($sformatf("early_valid_u%0d", w), early, 0);
        chk($sformatf("busy_wait_u%0d", w), allbusy, 1'b1);
        chk($sformatf("valid_u%0d", w), v_o[w], 1'b1);
        chk($sformatf("busy_resp_u%0d", w), b_o[w], 1'b1);
        chk($sformatf("data_u%0d", w), d_o[w], exp_d);
        chk($sformatf("err_u%0d", w), e_o[w], exp_e);
        tick();
        chk($sformatf("valid_end_u%0d", w), v_o[w], 1'b0);
        chk($sformatf("busy_end_u%0d", w), b_o[w], 1'b0);
        chk($sformatf("err_end_u%0d", w), e_o[w], 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0;
            ao_s[i] = '0; ai_s[i] = '0; di_s[i] = '0;
        end
        repeat (3) tick();
        chk("rst_data", d_o[0], 32'h0);
        chk("rst_valid", v_o[0], 1'b0);
        chk("rst_busy", b_o[0], 1'b0);
        chk("rst_err", e_o[0], 1'b0);
        chk("rst_busy_u1", b_o[1], 1'b0);
        chk("rst_busy_u2", b_o[2], 1'b0);
        rst_n = 1'b1;
        tick();

        // Write then read back; write-only completion leaves memdata alone.
        req(0, 1'b0, 1'b1, 32'd0, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'hDEADBEEF, 1'b0);

        // Simultaneous read+write returns the pre-write word.
        req(0, 1'b0, 1'b1, 32'd0, 32'd7, 32'h11111111, 32'hDEADBEEF, 1'b0);
        req(0, 1'b1, 1'b1, 32'd7, 32'd7, 32'h22222222, 32'h11111111, 1'b0);
        req(0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 32'h22222222, 1'b0);

        // Strobe during WAIT is ignored.
        rd_s[0] = 1'b1; ao_s[0] = 32'd5;
        tick();
        chk("wait_busy", b_o[0], 1'b1);
        chk("wait_novalid", v_o[0], 1'b0);
        ao_s[0] = 32'd7;
        tick();
        chk("wait_valid", v_o[0], 1'b1);
        chk("wait_data", d_o[0], 32'hDEADBEEF);
        rd_s[0] = 1'b0;
        tick();
        n = 0;
        repeat (3) begin
            tick();
            if (v_o[0]) n++;
        end
        chk("wait_single_valid", n, 0);

        // Strobe held through RESP is taken again once back in IDLE.
        rd_s[0] = 1'b1; ao_s[0] = 32'd7;
        tick();
        tick();
        chk("hold_valid1", v_o[0], 1'b1);
        chk("hold_data1", d_o[0], 32'h22222222);
        ao_s[0] = 32'd5;
        tick();
        chk("hold_idle_valid", v_o[0], 1'b0);
        chk("hold_idle_busy", b_o[0], 1'b0);
        tick();
        chk("hold_reaccept_busy", b_o[0], 1'b1);
        chk("hold_reaccept_novalid", v_o[0], 1'b0);
        tick();
        chk("hold_valid2", v_o[0], 1'b1);
        chk("hold_data2", d_o[0], 32'hDEADBEEF);
        rd_s[0] = 1'b0;
        tick();
        chk("hold_end_busy", b_o[0], 1'b0);

        // Reset during WAIT discards the pending write.
        req(0, 1'b0, 1'b1, 32'd0, 32'd3, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
        wr_s[0] = 1'b1; ai_s[0] = 32'd3; di_s[0] = 32'hFFFF0000;
        tick();
        chk("abort_busy", b_o[0], 1'b1);
        rst_n = 1'b0; wr_s[0] = 1'b0;
        tick();
        chk("abort_valid", v_o[0], 1'b0);
        chk("abort_busy_clr", b_o[0], 1'b0);
        chk("abort_data", d_o[0], 32'h0);
        chk("abort_err", e_o[0], 1'b0);
        rst_n = 1'b1;
        tick();
        chk("abort_no_late_valid", v_o[0], 1'b0);
        req(0, 1'b1, 1'b0, 32'd3, 32'd0, 32'd0, 32'hA5A5A5A5, 1'b0);

        // Address 64 is out of range, or aliases word 0 without the check.
        req(0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
        req(0, 1'b1, 1'b0, 32'd64, 32'd0, 32'd0, 32'h0, 1'b1);
`else
        req(0, 1'b1, 1'b0, 32'd64, 32'd0, 32'd0, 32'h0BADF00D, 1'b0);
`endif
        req(0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'h0BADF00D, 1'b0);

        // LAT=1: back-to-back reads complete every two cycles.
        req(1, 1'b0, 1'b1, 32'd0, 32'd1, 32'h1111AAAA, 32'h0, 1'b0);
        req(1, 1'b0, 1'b1, 32'd0, 32'd2, 32'h2222BBBB, 32'h0, 1'b0);
        rd_s[1] = 1'b1; ao_s[1] = 32'd1;
        tick();
        chk("b2b_valid1", v_o[1], 1'b1);
        chk("b2b_data1", d_o[1], 32'h1111AAAA);
        ao_s[1] = 32'd2;
        tick();
        chk("b2b_gap", v_o[1], 1'b0);
        tick();
        chk("b2b_valid2", v_o[1], 1'b1);
        chk("b2b_data2", d_o[1], 32'h2222BBBB);
        rd_s[1] = 1'b0;
        tick();
        chk("b2b_end_busy", b_o[1], 1'b0);

        // LAT=15: valid exactly fifteen cycles after the request.
        req(2, 1'b0, 1'b1, 32'd0, 32'd4, 32'hCAFE0015, 32'h0, 1'b0);
        req(2, 1'b1, 1'b0, 32'd4, 32'd0, 32'd0, 32'hCAFE0015, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
